prg_mem_arbiter: RTL and testbench

Arbitrates the single line-oriented DDR2 user port in the cartridge between two requesters. The SD boot loader writes game bytes; the CPU PRG-ROM path reads bytes. The block serializes both onto one request/ready/rvalid port, sequences each transaction, and returns the addressed byte to the CPU. It sits inside `cartridge`, between the SD/boot logic, the `prg_rom` interface and the DDR2 controller wrapper, in the DDR2 controller clock domain.

---
 rtl/prg_mem_arbiter_if.sv | 57 +++++
 rtl/prg_mem_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_prg_mem_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prg_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// prg_mem_arbiter_if
//
// Purpose:
//   Line-oriented DDR2 user port between the PRG memory arbiter and the DDR2
//   controller wrapper. One outstanding request at a time: the requester holds
//   mem_req_o with stable address/data/mask until mem_ready_i, and read data
//   comes back later on mem_rvalid_i.
//
// Signals (direction given from the arbiter side, i.e. the master modport):
//   mem_req_o    out 1          request, held until accepted
//   mem_we_o     out 1          1 = write, 0 = read
//   mem_addr_o   out ADDR_W-4   line address (16-byte lines)
//   mem_wdata_o  out 128        write byte replicated over the line
//   mem_wmask_o  out 16         one-hot byte enable, 0 on reads
//   mem_ready_i  in  1          request accepted this cycle
//   mem_rvalid_i in  1          read line valid
//   mem_rdata_i  in  128        read line, byte k = bits [8k+7:8k]
//
// Modports:
//   master : the arbiter
//   slave  : the DDR2 controller wrapper
// -----------------------------------------------------------------------------
interface prg_mem_arbiter_if #(
    parameter int ADDR_W = 20
);
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-5:0] mem_addr_o;
    logic [127:0]      mem_wdata_o;
    logic [15:0]       mem_wmask_o;
    logic              mem_ready_i;
    logic              mem_rvalid_i;
    logic [127:0]      mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_wdata_o,
        output mem_wmask_o,
        input  mem_ready_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_wmask_o,
        output mem_ready_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/prg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// prg_mem_arbiter
//
// Purpose:
//   Shares the single line-oriented DDR2 user port of the cartridge between
//   the SD boot loader (byte writes) and the CPU PRG-ROM path (byte reads).
//   Each requester has a one-entry pending register; a small FSM serializes
//   them onto the memory port, with a pending read always winning over a
//   pending write at IDLE. An issued transaction is never preempted.
//   Runs entirely in the DDR2 controller user clock domain.
//
// Optional feature (compile-time macro PRG_MEM_LINE_CACHE_EN):
//   A one-line read cache. Every read line returned in RD_WAIT is captured;
//   a CPU read that hits the cached line while the arbiter is idle with no
//   read pending completes on the next cycle without a memory request.
//   Accepted boot writes to the cached line patch the cached byte.
//   Without the macro every read goes to memory and no cache logic exists.
//
// Parameters:
//   ADDR_W          byte address width (line address is ADDR_W-4 bits)
//
// Ports:
//   clk_i           DDR2 controller user clock
//   rst_i           asynchronous active-high reset
//   boot_done_i     boot image fully loaded; blocks new boot writes
//   boot_wr_i       boot write strobe, qualified by boot_ready_o
//   boot_addr_i     boot write byte address
//   boot_data_i     boot write byte
//   boot_ready_o    write holding register empty and boot_done_i low
//   cpu_rd_i        one-cycle CPU read request
//   cpu_addr_i      CPU read byte address, sampled with cpu_rd_i
//   cpu_rd_data_o   read byte, valid with cpu_rd_valid_o
//   cpu_rd_valid_o  one-cycle read completion pulse
//   busy_o          FSM not idle or a request pending
//   mem             DDR2 user port (prg_mem_arbiter_if.master)
// -----------------------------------------------------------------------------
module prg_mem_arbiter #(
    parameter int ADDR_W = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              boot_done_i,
    input  logic              boot_wr_i,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic [7:0]        boot_data_i,
    output logic              boot_ready_o,

    input  logic              cpu_rd_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic [7:0]        cpu_rd_data_o,
    output logic              cpu_rd_valid_o,

    output logic              busy_o,

    prg_mem_arbiter_if.master mem
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_ISSUE = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_WAIT  = 2'd3
    } state_t;

    state_t            r_state;

    // Boot write holding register
    logic              r_wr_vld;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;

    // CPU read pending register
    logic              r_rd_vld;
    logic [ADDR_W-1:0] r_rd_addr;

    // Registered outputs
    logic              r_boot_ready;
    logic [7:0]        r_cpu_rd_data;
    logic              r_cpu_rd_valid;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-5:0] r_mem_addr;
    logic [127:0]      r_mem_wdata;
    logic [15:0]       r_mem_wmask;

`ifdef PRG_MEM_LINE_CACHE_EN
    logic              r_c_vld;
    logic [ADDR_W-5:0] r_c_tag;
    logic [127:0]      r_c_data;
`endif

    logic              w_rd_issued;
    logic              w_hit;
    logic              w_wr_take;
    logic              w_rd_take;
    logic              w_wr_done;
    logic              w_wr_vld_nxt;
    logic [ADDR_W-1:0] w_rd_addr_nxt;

    // Once a read has left IDLE its address is committed to the memory port;
    // a stray re-request from the CPU is dropped from then on.
    assign w_rd_issued = (r_state == ST_RD_ISSUE) || (r_state == ST_RD_WAIT);

`ifdef PRG_MEM_LINE_CACHE_EN
    assign w_hit = cpu_rd_i && (r_state == ST_IDLE) && !r_rd_vld && r_c_vld &&
                   (cpu_addr_i[ADDR_W-1:4] == r_c_tag);
`else
    assign w_hit = 1'b0;
`endif

    assign w_wr_take = boot_wr_i && boot_ready_o;
    assign w_rd_take = cpu_rd_i && !w_rd_issued && !w_hit;
    assign w_wr_done = (r_state == ST_WR_ISSUE) && mem.mem_ready_i;

    // boot_ready_o is registered from the next state of the holding register
    // so it drops right after capture and rises right after acceptance.
    assign w_wr_vld_nxt = (r_wr_vld && !w_wr_done) || w_wr_take;

    // A request arriving in the same cycle IDLE picks up the pending read
    // replaces it, so the issued address must follow it here too.
    assign w_rd_addr_nxt = w_rd_take ? cpu_addr_i : r_rd_addr;

    assign boot_ready_o   = r_boot_ready && !boot_done_i;
    assign cpu_rd_data_o  = r_cpu_rd_data;
    assign cpu_rd_valid_o = r_cpu_rd_valid;
    assign busy_o         = (r_state != ST_IDLE) || r_rd_vld || r_wr_vld;

    assign mem.mem_req_o   = r_mem_req;
    assign mem.mem_we_o    = r_mem_we;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_wdata_o = r_mem_wdata;
    assign mem.mem_wmask_o = r_mem_wmask;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_wr_vld       <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_rd_vld       <= 1'b0;
            r_rd_addr      <= '0;
            r_boot_ready   <= 1'b0;
            r_cpu_rd_data  <= '0;
            r_cpu_rd_valid <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_wmask    <= '0;
`ifdef PRG_MEM_LINE_CACHE_EN
            r_c_vld        <= 1'b0;
            r_c_tag        <= '0;
            r_c_data       <= '0;
`endif
        end else begin
            r_cpu_rd_valid <= 1'b0;
            r_boot_ready   <= !w_wr_vld_nxt;

            if (w_wr_take) begin
                r_wr_vld  <= 1'b1;
                r_wr_addr <= boot_addr_i;
                r_wr_data <= boot_data_i;
            end

            if (w_rd_take) begin
                r_rd_vld  <= 1'b1;
                r_rd_addr <= cpu_addr_i;
            end

`ifdef PRG_MEM_LINE_CACHE_EN
            if (w_hit) begin
                r_cpu_rd_data  <= r_c_data[{cpu_addr_i[3:0], 3'b000} +: 8];
                r_cpu_rd_valid <= 1'b1;
            end
`endif

            case (r_state)
                ST_IDLE: begin
                    if (r_rd_vld) begin
                        r_state     <= ST_RD_ISSUE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= w_rd_addr_nxt[ADDR_W-1:4];
                        r_mem_wmask <= '0;
                    end else if (r_wr_vld) begin
                        r_state     <= ST_WR_ISSUE;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wr_addr[ADDR_W-1:4];
                        r_mem_wdata <= {16{r_wr_data}};
                        r_mem_wmask <= 16'h0001 << r_wr_addr[3:0];
                    end
                end

                ST_WR_ISSUE: begin
                    if (mem.mem_ready_i) begin
                        r_state     <= ST_IDLE;
                        r_mem_req   <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_wmask <= '0;
                        r_wr_vld    <= 1'b0;
`ifdef PRG_MEM_LINE_CACHE_EN
                        // Keep the cached line coherent with accepted writes
                        if (r_c_vld && (r_wr_addr[ADDR_W-1:4] == r_c_tag)) begin
                            r_c_data[{r_wr_addr[3:0], 3'b000} +: 8] <= r_wr_data;
                        end
`endif
                    end
                end

                ST_RD_ISSUE: begin
                    if (mem.mem_ready_i) begin
                        r_state   <= ST_RD_WAIT;
                        r_mem_req <= 1'b0;
                    end
                end

                ST_RD_WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        r_state        <= ST_IDLE;
                        r_cpu_rd_data  <= mem.mem_rdata_i[{r_rd_addr[3:0], 3'b000} +: 8];
                        r_cpu_rd_valid <= 1'b1;
                        r_rd_vld       <= 1'b0;
`ifdef PRG_MEM_LINE_CACHE_EN
                        r_c_vld        <= 1'b1;
                        r_c_tag        <= r_mem_addr;
                        r_c_data       <= mem.mem_rdata_i;
`endif
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prg_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prg_mem_arbiter
//
// Directed bench for prg_mem_arbiter. Inputs change 1 ns after a rising edge
// and outputs are observed at the same point, so "cycle n" below is the
// interval after the n-th edge following a request.
// -----------------------------------------------------------------------------
module tb_prg_mem_arbiter;
    localparam int ADDR_W = 20;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              boot_done_i;
    logic              boot_wr_i;
    logic [ADDR_W-1:0] boot_addr_i;
    logic [7:0]        boot_data_i;
    logic              boot_ready_o;
    logic              cpu_rd_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [7:0]        cpu_rd_data_o;
    logic              cpu_rd_valid_o;
    logic              busy_o;

    int n_chk  = 0;
    int n_fail = 0;

    prg_mem_arbiter_if #(.ADDR_W(ADDR_W)) mem_if ();

    prg_mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .boot_done_i    (boot_done_i),
        .boot_wr_i      (boot_wr_i),
        .boot_addr_i    (boot_addr_i),
        .boot_data_i    (boot_data_i),
        .boot_ready_o   (boot_ready_o),
        .cpu_rd_i       (cpu_rd_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_rd_data_o  (cpu_rd_data_o),
        .cpu_rd_valid_o (cpu_rd_valid_o),
        .busy_o         (busy_o),
        .mem            (mem_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Line whose byte k is base+k, except byte idx which carries val
    function automatic logic [127:0] mk_line(input logic [7:0] base, input int idx,
                                             input logic [7:0] val);
        logic [127:0] l;
        for (int k = 0; k < 16; k++) begin
            l[8*k +: 8] = (k == idx) ? val : base + 8'(k);
        end
        return l;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-5:0] hold_addr;

        rst_i       = 1'b1;
        boot_done_i = 1'b0;
        boot_wr_i   = 1'b0;
        boot_addr_i = '0;
        boot_data_i = '0;
        cpu_rd_i    = 1'b0;
        cpu_addr_i  = '0;
        mem_if.mem_ready_i  = 1'b0;
        mem_if.mem_rvalid_i = 1'b0;
        mem_if.mem_rdata_i  = '0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_req",    mem_if.mem_req_o,   0);
        chk("rst_we",     mem_if.mem_we_o,    0);
        chk("rst_addr",   mem_if.mem_addr_o,  0);
        chk("rst_wmask",  mem_if.mem_wmask_o, 0);
        chk("rst_bready", boot_ready_o,       0);
        chk("rst_busy",   busy_o,             0);
        chk("rst_rdv",    cpu_rd_valid_o,     0);
        rst_i = 1'b0;
        step();
        chk("bready_after_rst", boot_ready_o, 1);

        // ---------------- boot write 0x00013 <- 0xA5, ready tied 1 ----------------
        mem_if.mem_ready_i = 1'b1;
        boot_wr_i   = 1'b1;
        boot_addr_i = 20'h00013;
        boot_data_i = 8'hA5;
        step();
        boot_wr_i = 1'b0;
        chk("wr_c1_bready", boot_ready_o,     0);
        chk("wr_c1_req",    mem_if.mem_req_o, 0);
        chk("wr_c1_busy",   busy_o,           1);
        step();
        chk("wr_c2_req",    mem_if.mem_req_o,   1);
        chk("wr_c2_we",     mem_if.mem_we_o,    1);
        chk("wr_c2_addr",   mem_if.mem_addr_o,  20'h00001 >> 0);
        chk("wr_c2_wmask",  mem_if.mem_wmask_o, 16'h0008);
        chk("wr_c2_wdata",  mem_if.mem_wdata_o, {16{8'hA5}});
        chk("wr_c2_bready", boot_ready_o,       0);
        step();
        chk("wr_c3_req",    mem_if.mem_req_o, 0);
        chk("wr_c3_bready", boot_ready_o,     1);
        chk("wr_c3_busy",   busy_o,           0);
        mem_if.mem_ready_i = 1'b0;

        // ---------------- CPU read 0x00017, rvalid 5 cycles after accept ----------------
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h00017;
        step();
        cpu_rd_i = 1'b0;
        chk("rd_c1_req", mem_if.mem_req_o, 0);
        step();
        chk("rd_c2_req",   mem_if.mem_req_o,   1);
        chk("rd_c2_we",    mem_if.mem_we_o,    0);
        chk("rd_c2_addr",  mem_if.mem_addr_o,  16'h0001);
        chk("rd_c2_wmask", mem_if.mem_wmask_o, 0);
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i = 1'b0;
        chk("rd_c3_req",  mem_if.mem_req_o, 0);
        chk("rd_c3_busy", busy_o,           1);
        repeat (4) step();
        chk("rd_c7_rdv", cpu_rd_valid_o, 0);
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = mk_line(8'h10, 7, 8'h3C);
        step();
        mem_if.mem_rvalid_i = 1'b0;
        chk("rd_c8_rdv",  cpu_rd_valid_o, 1);
        chk("rd_c8_data", cpu_rd_data_o,  8'h3C);
        step();
        chk("rd_c9_rdv",  cpu_rd_valid_o, 0);
        chk("rd_c9_busy", busy_o,         0);

        // ---------------- simultaneous read 0x00100 / write 0x00200, stalled ready ----------------
        cpu_rd_i    = 1'b1;
        cpu_addr_i  = 20'h00100;
        boot_wr_i   = 1'b1;
        boot_addr_i = 20'h00200;
        boot_data_i = 8'h5A;
        step();
        cpu_rd_i  = 1'b0;
        boot_wr_i = 1'b0;
        chk("sim_c1_bready", boot_ready_o,     0);
        chk("sim_c1_req",    mem_if.mem_req_o, 0);
        step();
        chk("sim_c2_req",  mem_if.mem_req_o,  1);
        chk("sim_c2_we",   mem_if.mem_we_o,   0);
        chk("sim_c2_addr", mem_if.mem_addr_o, 16'h0010);
        hold_addr = 16'h0010;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_bus", {mem_if.mem_req_o, mem_if.mem_we_o, mem_if.mem_addr_o},
                {1'b1, 1'b0, hold_addr});
            chk("stall_bready", boot_ready_o, 0);
        end
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i = 1'b0;
        chk("sim_acc_req",    mem_if.mem_req_o, 0);
        chk("sim_acc_bready", boot_ready_o,     0);
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = mk_line(8'h40, 0, 8'h99);
        step();
        mem_if.mem_rvalid_i = 1'b0;
        chk("sim_rd_rdv",    cpu_rd_valid_o,   1);
        chk("sim_rd_data",   cpu_rd_data_o,    8'h99);
        chk("sim_rd_req",    mem_if.mem_req_o, 0);
        chk("sim_rd_bready", boot_ready_o,     0);
        step();
        chk("sim_wr_req",    mem_if.mem_req_o,   1);
        chk("sim_wr_we",     mem_if.mem_we_o,    1);
        chk("sim_wr_addr",   mem_if.mem_addr_o,  16'h0020);
        chk("sim_wr_wmask",  mem_if.mem_wmask_o, 16'h0001);
        chk("sim_wr_wdata",  mem_if.mem_wdata_o, {16{8'h5A}});
        chk("sim_wr_bready", boot_ready_o,       0);
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i = 1'b0;
        chk("sim_end_req",    mem_if.mem_req_o, 0);
        chk("sim_end_bready", boot_ready_o,     1);
        chk("sim_end_busy",   busy_o,           0);

        // ---------------- re-request before issue replaces the address ----------------
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h00050;
        step();
        cpu_addr_i = 20'h00063;
        step();
        cpu_rd_i = 1'b0;
        chk("ovr_req",  mem_if.mem_req_o,  1);
        chk("ovr_addr", mem_if.mem_addr_o, 16'h0006);
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i  = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = mk_line(8'h80, 3, 8'hE1);
        step();
        mem_if.mem_rvalid_i = 1'b0;
        chk("ovr_data", cpu_rd_data_o, 8'hE1);

        // ---------------- boot_done blocks new writes, held write completes ----------------
        step();
        mem_if.mem_ready_i = 1'b1;
        boot_wr_i   = 1'b1;
        boot_addr_i = 20'h00305;
        boot_data_i = 8'h11;
        step();
        boot_wr_i   = 1'b0;
        boot_done_i = 1'b1;
        #1;
        chk("done_bready", boot_ready_o, 0);
        step();
        chk("done_wr_req",   mem_if.mem_req_o,   1);
        chk("done_wr_wmask", mem_if.mem_wmask_o, 16'h0020);
        step();
        chk("done_wr_end", mem_if.mem_req_o, 0);
        boot_wr_i = 1'b1;
        step();
        boot_wr_i = 1'b0;
        step();
        chk("done_blocked_req",    mem_if.mem_req_o, 0);
        chk("done_blocked_bready", boot_ready_o,     0);
        mem_if.mem_ready_i = 1'b0;
        boot_done_i = 1'b0;

        // ---------------- reset in RD_WAIT ----------------
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h00045;
        step();
        cpu_rd_i = 1'b0;
        step();
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i = 1'b0;
        chk("rw_busy", busy_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_req",    mem_if.mem_req_o,  0);
        chk("arst_addr",   mem_if.mem_addr_o, 0);
        chk("arst_busy",   busy_o,            0);
        chk("arst_bready", boot_ready_o,      0);
        chk("arst_rdata",  cpu_rd_data_o,     0);
        chk("arst_rdv",    cpu_rd_valid_o,    0);
        step();
        rst_i = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = mk_line(8'h20, 5, 8'h66);
        step();
        mem_if.mem_rvalid_i = 1'b0;
        chk("post_rst_rdv",    cpu_rd_valid_o,   0);
        chk("post_rst_req",    mem_if.mem_req_o, 0);
        chk("post_rst_bready", boot_ready_o,     1);
        step();
        chk("post_rst_rdv2", cpu_rd_valid_o,   0);
        chk("post_rst_req2", mem_if.mem_req_o, 0);
        chk("post_rst_busy", busy_o,           0);

`ifdef PRG_MEM_LINE_CACHE_EN
        // ---------------- line cache: miss 0x00020 then hit 0x0002F ----------------
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h00020;
        step();
        cpu_rd_i = 1'b0;
        step();
        chk("c_miss_req", mem_if.mem_req_o, 1);
        mem_if.mem_ready_i = 1'b1;
        step();
        mem_if.mem_ready_i  = 1'b0;
        mem_if.mem_rvalid_i = 1'b1;
        mem_if.mem_rdata_i  = mk_line(8'hC0, 0, 8'hC0);
        step();
        mem_if.mem_rvalid_i = 1'b0;
        chk("c_miss_data", cpu_rd_data_o, 8'hC0);
        step();
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h0002F;
        step();
        cpu_rd_i = 1'b0;
        chk("c_hit_rdv",  cpu_rd_valid_o,   1);
        chk("c_hit_data", cpu_rd_data_o,    8'hCF);
        chk("c_hit_req",  mem_if.mem_req_o, 0);
        step();
        chk("c_hit_req2", mem_if.mem_req_o, 0);
        chk("c_hit_rdv2", cpu_rd_valid_o,   0);
        chk("c_hit_busy", busy_o,           0);
        // write 0x77 to 0x0002F, then read it back as a hit
        mem_if.mem_ready_i = 1'b1;
        boot_wr_i   = 1'b1;
        boot_addr_i = 20'h0002F;
        boot_data_i = 8'h77;
        step();
        boot_wr_i = 1'b0;
        step();
        chk("c_wr_wmask", mem_if.mem_wmask_o, 16'h8000);
        step();
        mem_if.mem_ready_i = 1'b0;
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 20'h0002F;
        step();
        cpu_rd_i = 1'b0;
        chk("c_upd_rdv",  cpu_rd_valid_o,   1);
        chk("c_upd_data", cpu_rd_data_o,    8'h77);
        chk("c_upd_req",  mem_if.mem_req_o, 0);
        step();
        chk("c_upd_req2", mem_if.mem_req_o, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
